ldtu_word_scheduler: RTL

- Sits between the LiTe-DTU encoder and the output serializer.
- Takes 32-bit words from either the normal encoder path (DATA_32/Load) or the fallback path (DATA_32_FB/Load_FB), selected by fallback_.
- Buffers accepted words in a small FIFO and hands one word to the serializer per request; idle words fill the gaps.
- Inserts a mode-switch marker word whenever fallback_ changes, so the back-end can realign its decoding.

---
 rtl/ldtu_word_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ldtu_word_scheduler.sv
// ldtu_word_scheduler
// Buffers 32-bit words from the LiTe-DTU encoder (normal or fallback path),
// inserts a mode-switch marker whenever fallback_ changes, and hands one word
// per ser_ready request to the serializer, filling gaps with IDLE_WORD.
// Optional build macro LDTU_SCHED_STATS_EN adds saturating words_sent /
// words_dropped counters, cleared together with the overflow flag.
module ldtu_word_scheduler #(
   parameter int          DEPTH      = 8,
   parameter int          AW         = 3,
   parameter logic [31:0] IDLE_WORD  = 32'hEAAAAAAA,
   parameter logic [4:0]  SWITCH_HDR = 5'b11101
) (
   input  logic          CLK_,
   input  logic          reset,
   input  logic          fallback_,
   input  logic [31:0]   DATA_32,
   input  logic          Load,
   input  logic [31:0]   DATA_32_FB,
   input  logic          Load_FB,
   input  logic          ser_ready,
   input  logic          clr_ovf,
   output logic [31:0]   DATA_out,
   output logic          DATA_valid,
   output logic          overflow,
   output logic [AW:0]   fifo_level
`ifdef LDTU_SCHED_STATS_EN
   ,
   output logic [15:0]   words_sent,
   output logic [15:0]   words_dropped
`endif
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_RUN        = 2'd1;
   localparam logic [1:0] S_MARK       = 2'd2;
   localparam logic [1:0] S_DRAIN_SKID = 2'd3;

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [1:0]  state, state_nxt;
   logic        fb_d, sw;
   logic        in_load;
   logic [31:0] in_word;
   logic [31:0] marker;

   logic        skid_vld, skid_vld_nxt, skid_load, skid_drop;
   logic [31:0] skid_word;

   logic [31:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, level;
   logic        full, empty, pop;
   logic        push_req, push_ok, push_drop;
   logic [31:0] push_word;

   assign in_load = fallback_ ? Load_FB : Load;
   assign in_word = fallback_ ? DATA_32_FB : DATA_32;
   assign sw      = fallback_ ^ fb_d;
   // Marker carries the mode being switched into in its LSB
   assign marker  = {SWITCH_HDR, 26'b0, fallback_};

   assign level      = wr_ptr - rd_ptr;
   assign full       = (level == FULL_LVL);
   assign empty      = (level == '0);
   assign pop        = ser_ready & ~empty;
   // A pop frees the slot before the push lands, so full+pop never drops
   assign push_ok    = push_req & (~full | pop);
   assign push_drop  = push_req & full & ~pop;
   assign fifo_level = level;

   // FSM: chooses the single word pushed this cycle and manages the skid slot
   always_comb begin
      state_nxt    = state;
      push_req     = 1'b0;
      push_word    = in_word;
      skid_load    = 1'b0;
      skid_drop    = 1'b0;
      skid_vld_nxt = skid_vld;
      case (state)
         S_IDLE: begin
            // Mode changes before the first accepted word need no marker
            push_req = in_load;
            if (in_load) state_nxt = S_RUN;
         end
         S_RUN: begin
            push_req = in_load;
            if (sw) state_nxt = S_MARK;
         end
         S_MARK: begin
            push_req  = 1'b1;
            push_word = marker;
            // The skid slot holds one word; a second one has nowhere to go
            if (in_load) begin
               if (skid_vld) begin
                  skid_drop = 1'b1;
               end else begin
                  skid_load    = 1'b1;
                  skid_vld_nxt = 1'b1;
               end
            end
            if (sw)                state_nxt = S_MARK;
            else if (skid_vld_nxt) state_nxt = S_DRAIN_SKID;
            else                   state_nxt = S_RUN;
         end
         S_DRAIN_SKID: begin
            push_req     = skid_vld;
            push_word    = skid_word;
            skid_load    = in_load;
            skid_vld_nxt = in_load;
            if (sw)           state_nxt = S_MARK;
            else if (in_load) state_nxt = S_DRAIN_SKID;
            else              state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control registers: FSM state, mode history, skid valid, pointers
   always_ff @(posedge CLK_) begin
      if (!reset) begin
         state    <= S_IDLE;
         fb_d     <= fallback_;
         skid_vld <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         fb_d     <= fallback_;
         skid_vld <= skid_vld_nxt;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Data storage: FIFO array and skid word carry no reset
   always_ff @(posedge CLK_) begin
      if (push_ok)   mem[wr_ptr[AW-1:0]] <= push_word;
      if (skid_load) skid_word           <= in_word;
   end

   // Serializer output: registered head word, held while ser_ready is low
   always_ff @(posedge CLK_) begin
      if (!reset) begin
         DATA_out   <= IDLE_WORD;
         DATA_valid <= 1'b0;
      end else if (ser_ready) begin
         DATA_out   <= empty ? IDLE_WORD : mem[rd_ptr[AW-1:0]];
         DATA_valid <= ~empty;
      end
   end

   // Sticky overflow: a drop in the same cycle as clr_ovf keeps it set
   always_ff @(posedge CLK_) begin
      if (!reset)                      overflow <= 1'b0;
      else if (push_drop || skid_drop) overflow <= 1'b1;
      else if (clr_ovf)                overflow <= 1'b0;
   end

`ifdef LDTU_SCHED_STATS_EN
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [1:0] drop_n;
   assign drop_n = {1'b0, push_drop} + {1'b0, skid_drop};

   // Saturating delivery and loss counters, cleared with the overflow flag
   always_ff @(posedge CLK_) begin
      if (!reset || clr_ovf) begin
         words_sent    <= '0;
         words_dropped <= '0;
      end else begin
         words_sent    <= sat_add(words_sent, {1'b0, pop});
         words_dropped <= sat_add(words_dropped, drop_n);
      end
   end
`endif

endmodule
